// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters for the RV32I fetch stage.
// Optional statistics counters are built only when BP_STATS_EN is defined.
module branch_predictor #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       cnt_q    [ENTRIES];

  // Lookup path
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [XLEN-1:0]  if_pc_next;

  assign lk_idx      = if_pc[IDX_W+1:2];
  assign lk_tag      = if_pc[XLEN-1:IDX_W+2];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign if_pc_next  = if_pc + PC_STEP;
  assign pred_taken  = lk_hit && cnt_q[lk_idx][1];
  assign pred_target = pred_taken ? target_q[lk_idx] : if_pc_next;

  // Update path
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       cnt_d;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[XLEN-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q[up_idx];
    if (upd_taken) begin
      if (cnt_q[up_idx] != 2'b11) cnt_d = cnt_q[up_idx] + 2'd1;
    end else begin
      if (cnt_q[up_idx] != 2'b00) cnt_d = cnt_q[up_idx] - 2'd1;
    end
  end

  // NOTE: the table is flops, not RAM, so every entry is cleared on reset;
  // stale valid bits would otherwise produce bogus predictions after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        cnt_q[up_idx] <= cnt_d;
        if (upd_taken) target_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        cnt_q[up_idx]    <= 2'b10;
      end
    end
  end

  // Resolution check against the prediction carried down the pipe
  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = (upd_valid && upd_taken) ? upd_target : upd_pc + PC_STEP;

`ifdef BP_STATS_EN
  logic [31:0] upd_cnt_q;
  logic [31:0] misp_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      upd_cnt_q  <= '0;
      misp_cnt_q <= '0;
    end else begin
      if (upd_valid && (upd_cnt_q != 32'hFFFF_FFFF))   upd_cnt_q  <= upd_cnt_q + 32'd1;
      if (mispredict && (misp_cnt_q != 32'hFFFF_FFFF)) misp_cnt_q <= misp_cnt_q + 32'd1;
    end
  end

  assign stat_updates     = upd_cnt_q;
  assign stat_mispredicts = misp_cnt_q;
`else
  assign stat_updates     = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, XLEN=32).
// Statistics expectations follow whether BP_STATS_EN is defined for the build.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  branch_predictor #(.XLEN(32), .ENTRIES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic [31:0] ptgt);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = taken;
    upd_target      = tgt;
    upd_pred_taken  = ptaken;
    upd_pred_target = ptgt;
    #1;
  endtask

  task automatic idle();
    upd_valid = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  logic [31:0] exp_upd;
  logic [31:0] exp_misp;

  initial begin
    reset = 1'b1; if_pc = 32'h100;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    tick(); tick();
    check("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
    reset = 1'b0;
    #1;

    // Cold lookup
    check("cold_taken", {31'd0, pred_taken}, 32'd0);
    check("cold_target", pred_target, 32'h104);
    check("cold_stat_upd", stat_updates, 32'd0);

    // Allocate 0x100 -> 0x80; same-cycle lookup sees old contents
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    check("alloc_misp", {31'd0, mispredict}, 32'd1);
    check("alloc_redirect", redirect_pc, 32'h80);
    check("alloc_no_bypass", {31'd0, pred_taken}, 32'd0);
    tick(); idle();
    check("alloc_hit_taken", {31'd0, pred_taken}, 32'd1);
    check("alloc_hit_target", pred_target, 32'h80);

    // Not-taken: cnt 10 -> 01
    drive_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    check("nt_misp", {31'd0, mispredict}, 32'd1);
    check("nt_redirect", redirect_pc, 32'h104);
    tick(); idle();
    check("cnt01_taken", {31'd0, pred_taken}, 32'd0);
    check("cnt01_target", pred_target, 32'h104);

    // Two more not-taken: cnt -> 00, correctly predicted
    drive_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    check("nt2_no_misp", {31'd0, mispredict}, 32'd0);
    tick();
    drive_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    tick(); idle();
    check("cnt00_taken", {31'd0, pred_taken}, 32'd0);

    // Taken x1: 00 -> 01, still not taken
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick(); idle();
    check("cnt00to01_taken", {31'd0, pred_taken}, 32'd0);
    // Taken x2: 01 -> 10
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick(); idle();
    check("cnt10_taken", {31'd0, pred_taken}, 32'd1);
    // Taken x3 and x4: 10 -> 11 -> 11 (correct predictions)
    drive_upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    check("correct_no_misp", {31'd0, mispredict}, 32'd0);
    tick();
    drive_upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
    tick();
    // One not-taken: 11 -> 10, still taken
    drive_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    tick(); idle();
    check("sat_cnt10_taken", {31'd0, pred_taken}, 32'd1);
    check("sat_cnt10_target", pred_target, 32'h80);

    // Aliasing: 0x140 shares index 0 with 0x100
    look(32'h140);
    check("alias_miss_taken", {31'd0, pred_taken}, 32'd0);
    check("alias_miss_target", pred_target, 32'h144);
    drive_upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    tick(); idle();
    check("alias_hit_taken", {31'd0, pred_taken}, 32'd1);
    check("alias_hit_target", pred_target, 32'h300);
    look(32'h100);
    check("evicted_taken", {31'd0, pred_taken}, 32'd0);
    check("evicted_target", pred_target, 32'h104);

    // Re-allocate 0x100 -> 0x80, then retarget to 0x200
    drive_upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    tick(); idle();
    check("realloc_target", pred_target, 32'h80);
    drive_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h80);
    check("retarget_misp", {31'd0, mispredict}, 32'd1);
    check("retarget_redirect", redirect_pc, 32'h200);
    check("retarget_old_lookup", pred_target, 32'h80);
    tick(); idle();
    check("retarget_new_target", pred_target, 32'h200);

    // Wrap-around boundaries
    look(32'hFFFF_FFFC);
    check("wrap_pred_target", pred_target, 32'h0);
    upd_pc = 32'hFFFF_FFFC; upd_taken = 1'b1; upd_target = 32'h40;
    #1;
    check("idle_no_misp", {31'd0, mispredict}, 32'd0);
    check("idle_redirect_wrap", redirect_pc, 32'h0);

    // Reset beats a coincident update and clears learned state
    reset = 1'b1;
    drive_upd(32'h400, 1'b1, 32'h500, 1'b0, 32'h404);
    tick();
    reset = 1'b0; idle();
    look(32'h400);
    check("rst_upd_dropped", {31'd0, pred_taken}, 32'd0);
    check("rst_upd_target", pred_target, 32'h404);
    look(32'h100);
    check("rst_cleared_0x100", {31'd0, pred_taken}, 32'd0);
    check("rst_stat_upd", stat_updates, 32'd0);
    check("rst_stat_misp", stat_mispredicts, 32'd0);

    // Statistics: 5 updates, 2 mispredicts
    drive_upd(32'h10, 1'b1, 32'h20, 1'b0, 32'h14);
    check("st1_misp", {31'd0, mispredict}, 32'd1);
    tick();
    drive_upd(32'h10, 1'b1, 32'h20, 1'b1, 32'h20);
    check("st2_misp", {31'd0, mispredict}, 32'd0);
    tick();
    drive_upd(32'h10, 1'b0, 32'h0, 1'b1, 32'h20);
    check("st3_misp", {31'd0, mispredict}, 32'd1);
    tick();
    drive_upd(32'h50, 1'b0, 32'h0, 1'b0, 32'h54);
    check("st4_misp", {31'd0, mispredict}, 32'd0);
    tick();
    drive_upd(32'h10, 1'b1, 32'h20, 1'b1, 32'h20);
    check("st5_misp", {31'd0, mispredict}, 32'd0);
    tick(); idle();
`ifdef BP_STATS_EN
    exp_upd = 32'd5; exp_misp = 32'd2;
`else
    exp_upd = 32'd0; exp_misp = 32'd0;
`endif
    check("stat_updates", stat_updates, exp_upd);
    check("stat_mispredicts", stat_mispredicts, exp_misp);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch prediction unit for the five-stage RV32I pipeline: a direct-mapped branch target buffer with per-entry 2-bit saturating counters. The IF stage looks it up to choose the next PC instead of always falling through to `pc+4`. Resolved branches and jumps from the EX/MEM boundary train it, and the same update port reports mispredictions so hazard logic can flush IF/ID and ID/EX and redirect `pc`.

## Interface
Parameters:
- `XLEN`, 32, address/data width.
- `ENTRIES`, 16, BTB entries; power of two, ≥2.
  - `IDX_W = clog2(ENTRIES)`.
  - `TAG_W = XLEN-IDX_W-2`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_pc`  in  XLEN  current fetch PC.
- `pred_taken`  out  1  lookup result: predicted taken.
- `pred_target`  out  XLEN  predicted next PC.
- `upd_valid`  in  1  resolved control-flow instruction present this cycle.
- `upd_pc`  in  XLEN  PC of the resolved instruction.
- `upd_taken`  in  1  actual outcome.
- `upd_target`  in  XLEN  actual taken target.
- `upd_pred_taken`  in  1  prediction made at fetch, carried down the pipeline.
- `upd_pred_target`  in  XLEN  predicted target made at fetch, carried down the pipeline.
- `mispredict`  out  1  flush request.
- `redirect_pc`  out  XLEN  correct next PC when `mispredict` is 1.
- `stat_updates`  out  32  count of update cycles.
- `stat_mispredicts`  out  32  count of mispredict cycles.

## Operation
- Each entry holds `valid`, `tag[TAG_W]`, `target[XLEN]` and `cnt[2]`.
  - Index = `pc[IDX_W+1:2]`.
  - Tag = `pc[XLEN-1:IDX_W+2]`.
- Lookup (combinational):
  - `hit` = `valid` && tag match.
  - `pred_taken` = `hit && cnt[1]`.
  - `pred_target` = `pred_taken ? target : if_pc+4`.
- Update (registered) when `upd_valid=1`:
  - Hit: `cnt` saturating +1 if `upd_taken`, else saturating −1 (floor 00, ceiling 11). `target` is overwritten with `upd_target` only when `upd_taken`.
  - Miss and `upd_taken`: allocate/replace the entry with `valid=1`, new tag, `target=upd_target`, `cnt=10` (weakly taken).
  - Miss and not taken: no change.
- Mispredict (combinational, gated by `upd_valid`):
  - `mispredict` = `(upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_target)`.
  - `redirect_pc` = `upd_taken ? upd_target : upd_pc+4`.
  - When `upd_valid=0`: `mispredict=0`, `redirect_pc=upd_pc+4`.
- `+4` arithmetic wraps modulo 2^XLEN. `pc[1:0]` is ignored.
- Replacement policy: direct-mapped, new taken branch always evicts the aliased entry.

## Timing
- Lookup latency 0 cycles. Update visible to lookup on the cycle after the update edge.
- Same-cycle update and lookup of the same index: lookup returns pre-update contents; no bypass.
- `mispredict`/`redirect_pc` are valid in the same cycle as `upd_valid`. The consumer registers them.
- Reset:
  - All `valid=0`, `cnt=01`, `target=0`, statistics 0.
  - Outputs during/after reset: `pred_taken=0`, `pred_target=if_pc+4`.
  - Reset takes priority over a coincident `upd_valid`; that update is discarded.
  - Reset asserted mid-training clears all learned state.

## Configuration
- `BP_STATS_EN` defined:
  - `stat_updates` increments on every `upd_valid` cycle.
  - `stat_mispredicts` increments on every `mispredict` cycle.
  - Both saturate at `32'hFFFF_FFFF` and clear on reset.
- Undefined: counters are not synthesised; both ports are tied to 0.
- Prediction behaviour is identical in both builds.

## Test plan
- Cold lookup: reset, `if_pc=0x100` -> `pred_taken=0`, `pred_target=0x104`.
- Allocate: `upd_valid=1`, `upd_pc=0x100`, `upd_taken=1`, `upd_target=0x80`, `upd_pred_taken=0`.
  - Same cycle: `mispredict=1`, `redirect_pc=0x80`.
  - Next cycle, `if_pc=0x100`: `pred_taken=1`, `pred_target=0x80`.
- Counter saturation on `0x100`:
  - One not-taken update -> `cnt=01`, `pred_taken=0`.
  - Two more not-taken -> `cnt=00`.
  - Three taken -> `cnt=11`; a fourth taken stays 11.
  - One not-taken -> `cnt=10`, `pred_taken=1`.
- Aliasing with `ENTRIES=16`:
  - `0x100` trained taken; `if_pc=0x140` (same index, different tag) -> miss, `pred_target=0x144`.
  - Taken update at `0x140` -> `0x140` hits; `0x100` now misses.
- Target change and boundaries:
  - Hit at `0x100` predicting `0x80`, resolved taken to `0x200` -> `mispredict=1`, `redirect_pc=0x200`; stored target becomes `0x200`.
  - Same-cycle lookup of `0x100` still returns `0x80`.
  - `if_pc=0xFFFF_FFFC` miss -> `pred_target=0x0`.
  - Reset asserted with `upd_valid=1` -> no allocation.
- Statistics (build with `BP_STATS_EN`): 5 updates, 2 of them mispredicts -> `stat_updates=5`, `stat_mispredicts=2`. Without the macro -> both 0.
